// File: rtl/stage_sequencer_if.sv
// Host/datapath-facing bundle for the stage sequencer.
//   master : host/datapath side; drives control and handshake inputs, observes stage outputs
//   slave  : sequencer side; samples control/handshake, drives stage enables, state, busy, retired
interface stage_sequencer_if #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned EXEC_W = 4
);
    logic              start;
    logic              halt_req;
    logic              mem_ack;
    logic [EXEC_W-1:0] exec_cycles;
    logic              mem_req;
    logic              fetch_en;
    logic              decode_en;
    logic              exec_en;
    logic              wb_en;
    logic [2:0]        state;
    logic              busy;
    logic [CNT_W-1:0]  retired;

    modport master (
        output start, halt_req, mem_ack, exec_cycles,
        input  mem_req, fetch_en, decode_en, exec_en, wb_en, state, busy, retired
    );

    modport slave (
        input  start, halt_req, mem_ack, exec_cycles,
        output mem_req, fetch_en, decode_en, exec_en, wb_en, state, busy, retired
    );
endinterface

// File: rtl/stage_sequencer.sv
// Multicycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer.
// Waits on the instruction-memory handshake in FETCH, holds EXECUTE for a
// per-instruction cycle count, honours host start/halt and counts retired
// instructions.
// Ports:
//   clock  : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : stage_sequencer_if.slave (start, halt_req, mem_ack, exec_cycles in;
//            mem_req, fetch_en, decode_en, exec_en, wb_en, state, busy, retired out)
module stage_sequencer #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned EXEC_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    stage_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_FETCH     = 3'b000,
        ST_DECODE    = 3'b001,
        ST_EXECUTE   = 3'b010,
        ST_WRITEBACK = 3'b011,
        ST_IDLE      = 3'b100
    } state_t;

    state_t            state_q;
    logic              halt_pend_q;
    logic [EXEC_W-1:0] exec_cnt_q;
    logic [CNT_W-1:0]  retired_q;

    // State register, halt latch, execute down-counter and retire counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            halt_pend_q <= 1'b0;
            exec_cnt_q  <= '0;
            retired_q   <= '0;
        end else begin
            // Halt requests are only remembered while an instruction is in flight.
            if ((state_q != ST_IDLE) && bus.halt_req) begin
                halt_pend_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (bus.mem_ack) begin
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_q    <= ST_EXECUTE;
                    // Zero-length execute is stretched to one cycle.
                    exec_cnt_q <= (bus.exec_cycles == '0) ? EXEC_W'(1) : bus.exec_cycles;
                end
                ST_EXECUTE: begin
                    if ((exec_cnt_q == EXEC_W'(1)) || (exec_cnt_q == '0)) begin
                        state_q <= ST_WRITEBACK;
                    end else begin
                        exec_cnt_q <= exec_cnt_q - EXEC_W'(1);
                    end
                end
                ST_WRITEBACK: begin
                    retired_q <= retired_q + CNT_W'(1);
                    // A halt raised in this very cycle still stops at this exit.
                    if (halt_pend_q || bus.halt_req) begin
                        state_q     <= ST_IDLE;
                        halt_pend_q <= 1'b0;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                default: begin
                    // Unused encodings recover to IDLE.
                    state_q     <= ST_IDLE;
                    halt_pend_q <= 1'b0;
                end
            endcase
        end
    end

    // Moore decode of stage enables from the state register.
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.fetch_en  = 1'b0;
        bus.decode_en = 1'b0;
        bus.exec_en   = 1'b0;
        bus.wb_en     = 1'b0;
        bus.busy      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                bus.mem_req  = 1'b1;
                bus.fetch_en = 1'b1;
                bus.busy     = 1'b1;
            end
            ST_DECODE: begin
                bus.decode_en = 1'b1;
                bus.busy      = 1'b1;
            end
            ST_EXECUTE: begin
                bus.exec_en = 1'b1;
                bus.busy    = 1'b1;
            end
            ST_WRITEBACK: begin
                bus.wb_en = 1'b1;
                bus.busy  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.state   = state_q;
    assign bus.retired = retired_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: two instances (16-bit and 4-bit retire
// counters) share one directed stimulus stream; expected per-cycle outputs are
// queued by the stimulus and popped by an independent negedge monitor.
module tb_stage_sequencer;

    localparam logic [2:0] S_F = 3'b000;
    localparam logic [2:0] S_D = 3'b001;
    localparam logic [2:0] S_E = 3'b010;
    localparam logic [2:0] S_W = 3'b011;
    localparam logic [2:0] S_I = 3'b100;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        int         ret;
        int         ph;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       start;
    logic       halt_req;
    logic       mem_ack;
    logic [3:0] exec_cycles;

    int   cyc;
    int   ph;
    int   checks;
    int   failures;
    exp_t q[$];

    stage_sequencer_if #(.CNT_W(16), .EXEC_W(4)) bus16();
    stage_sequencer_if #(.CNT_W(4),  .EXEC_W(4)) bus4();

    assign bus16.start       = start;
    assign bus16.halt_req    = halt_req;
    assign bus16.mem_ack     = mem_ack;
    assign bus16.exec_cycles = exec_cycles;
    assign bus4.start        = start;
    assign bus4.halt_req     = halt_req;
    assign bus4.mem_ack      = mem_ack;
    assign bus4.exec_cycles  = exec_cycles;

    stage_sequencer #(.CNT_W(16), .EXEC_W(4)) dut16 (
        .clock (clock),
        .reset (reset),
        .bus   (bus16)
    );

    stage_sequencer #(.CNT_W(4), .EXEC_W(4)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Expected {mem_req, fetch_en, decode_en, exec_en, wb_en, busy} per state.
    function automatic logic [5:0] ctrl_of(input logic [2:0] s);
        case (s)
            S_F:     return 6'b110001;
            S_D:     return 6'b001001;
            S_E:     return 6'b000101;
            S_W:     return 6'b000011;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic cmp(input string name, input int p, input int c,
                       input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s ph=%0d cyc=%0d got=%0h exp=%0h", name, p, c, got, want);
        end
    endtask

    // Monitor: compares every DUT output against the entry queued for this cycle.
    always @(negedge clock) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            cmp("stale_expectation", e.ph, e.cyc, 32'(cyc), 32'(e.cyc));
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            cmp("state16",   e.ph, cyc, 32'(bus16.state), 32'(e.st));
            cmp("ctrl16",    e.ph, cyc,
                32'({bus16.mem_req, bus16.fetch_en, bus16.decode_en,
                     bus16.exec_en, bus16.wb_en, bus16.busy}), 32'(ctrl_of(e.st)));
            cmp("retired16", e.ph, cyc, 32'(bus16.retired), 32'(e.ret & 32'hFFFF));
            cmp("state4",    e.ph, cyc, 32'(bus4.state), 32'(e.st));
            cmp("ctrl4",     e.ph, cyc,
                32'({bus4.mem_req, bus4.fetch_en, bus4.decode_en,
                     bus4.exec_en, bus4.wb_en, bus4.busy}), 32'(ctrl_of(e.st)));
            cmp("retired4",  e.ph, cyc, 32'(bus4.retired), 32'(e.ret & 32'hF));
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic s, input logic h, input logic a,
                        input logic [3:0] ex, input logic [2:0] est, input int eret);
        exp_t e;
        @(negedge clock);
        reset       = r;
        start       = s;
        halt_req    = h;
        mem_ack     = a;
        exec_cycles = ex;
        e.cyc = cyc + 1;
        e.st  = est;
        e.ret = eret;
        e.ph  = ph;
        q.push_back(e);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        start       = 1'b0;
        halt_req    = 1'b0;
        mem_ack     = 1'b0;
        exec_cycles = 4'd0;

        // Reset state
        ph = 0;
        step(1, 0, 0, 0, 4'd0, S_I, 0);
        step(1, 0, 0, 1, 4'd0, S_I, 0);

        // Minimal 4-cycle instructions, ack tied high
        ph = 1;
        step(0, 1, 0, 1, 4'd1, S_F, 0);
        step(0, 0, 0, 1, 4'd1, S_D, 0);
        step(0, 0, 0, 1, 4'd1, S_E, 0);
        step(0, 0, 0, 1, 4'd1, S_W, 0);
        step(0, 0, 0, 1, 4'd1, S_F, 1);
        step(0, 0, 0, 1, 4'd1, S_D, 1);
        step(0, 0, 0, 1, 4'd1, S_E, 1);
        step(0, 0, 0, 1, 4'd1, S_W, 1);
        step(0, 0, 0, 1, 4'd1, S_F, 2);

        // Fetch wait states: three unacked FETCH cycles then ack
        ph = 2;
        step(0, 0, 0, 0, 4'd1, S_F, 2);
        step(0, 0, 0, 0, 4'd1, S_F, 2);
        step(0, 0, 0, 0, 4'd1, S_F, 2);
        step(0, 0, 0, 1, 4'd1, S_D, 2);

        // exec_cycles=5 in DECODE, changed to 2 mid-EXECUTE
        ph = 3;
        step(0, 0, 0, 1, 4'd5, S_E, 2);
        step(0, 0, 0, 1, 4'd2, S_E, 2);
        step(0, 0, 0, 1, 4'd2, S_E, 2);
        step(0, 0, 0, 1, 4'd2, S_E, 2);
        step(0, 0, 0, 1, 4'd2, S_E, 2);
        step(0, 0, 0, 1, 4'd2, S_W, 2);
        step(0, 0, 0, 1, 4'd2, S_F, 3);

        // exec_cycles=0 gives one EXECUTE cycle
        ph = 4;
        step(0, 0, 0, 1, 4'd0, S_D, 3);
        step(0, 0, 0, 1, 4'd0, S_E, 3);
        step(0, 0, 0, 1, 4'd0, S_W, 3);
        step(0, 0, 0, 1, 4'd0, S_F, 4);

        // Halt pulsed during EXECUTE
        ph = 5;
        step(0, 0, 0, 1, 4'd3, S_D, 4);
        step(0, 0, 0, 1, 4'd3, S_E, 4);
        step(0, 0, 1, 1, 4'd3, S_E, 4);
        step(0, 0, 0, 1, 4'd3, S_E, 4);
        step(0, 0, 0, 1, 4'd3, S_W, 4);
        step(0, 0, 0, 1, 4'd3, S_I, 5);

        // Idle ignores ack; restart, halt pulsed in WRITEBACK
        ph = 6;
        step(0, 0, 0, 1, 4'd1, S_I, 5);
        step(0, 0, 0, 0, 4'd1, S_I, 5);
        step(0, 1, 0, 0, 4'd1, S_F, 5);
        step(0, 0, 0, 1, 4'd1, S_D, 5);
        step(0, 0, 0, 1, 4'd1, S_E, 5);
        step(0, 0, 0, 1, 4'd1, S_W, 5);
        step(0, 0, 1, 1, 4'd1, S_I, 6);

        // Halt in IDLE ignored; restart runs without stale halt
        ph = 7;
        step(0, 0, 1, 1, 4'd1, S_I, 6);
        step(0, 1, 0, 0, 4'd1, S_F, 6);
        step(0, 0, 0, 1, 4'd1, S_D, 6);
        step(0, 0, 0, 1, 4'd1, S_E, 6);
        step(0, 0, 0, 1, 4'd1, S_W, 6);
        step(0, 0, 0, 0, 4'd1, S_F, 7);

        // Reset in FETCH with retired=7; ack pulses in IDLE
        ph = 8;
        step(1, 0, 0, 1, 4'd1, S_I, 0);
        step(0, 0, 0, 1, 4'd1, S_I, 0);
        step(0, 0, 0, 0, 4'd1, S_I, 0);
        step(0, 0, 0, 1, 4'd1, S_I, 0);

        // Sixteen instructions: 4-bit counter wraps to 0
        ph = 9;
        step(0, 1, 0, 1, 4'd1, S_F, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 1, 4'd1, S_D, i);
            step(0, 0, 0, 1, 4'd1, S_E, i);
            step(0, 0, 0, 1, 4'd1, S_W, i);
            step(0, 0, 0, 1, 4'd1, S_F, i + 1);
        end

        // Halt from FETCH stops after the instruction retires
        ph = 10;
        step(0, 0, 1, 1, 4'd1, S_D, 16);
        step(0, 0, 0, 1, 4'd1, S_E, 16);
        step(0, 0, 0, 1, 4'd1, S_W, 16);
        step(0, 0, 0, 1, 4'd1, S_I, 17);
        step(0, 0, 0, 1, 4'd1, S_I, 17);

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(negedge clock);
            #1;
        end
        cmp("scoreboard_drain", ph, cyc, 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
